core5_cpu_0_debug_ocimem_ctrl: RTL
==================================

// Module: core5_cpu_0_debug_ocimem_ctrl
// PURPOSE
//  Downstream consumer of the JTAG debug sysclk stage: decodes jdo[37:0] and take_*_ocimem_* pulses.
//  Owns the 32-bit on-chip debug memory (OCIMEM) and the monitor handshake flags.
//  Returns MonDReg/monitor_ready/monitor_error to the JTAG tck stage.
//  CPU side is an Avalon-MM slave; JTAG has priority over CPU on the single-port RAM.
// PARAMETERS
//  ADDR_W     8  word-address width; RAM depth = 2**ADDR_W x 32
//  ROM_WORDS  64 low words write-protected from CPU (only with CORE5_OCIMEM_WRITE_PROTECT_EN)
// PORTS
//  clk                      in  1        system clock
//  reset_n                  in  1        async active-low reset
//  jdo                      in  38       JTAG data, stable while any take_* pulse is high
//  take_action_ocimem_a     in  1        1-cycle pulse: address/control command
//  take_action_ocimem_b     in  1        1-cycle pulse: write jdo[34:3] at MonAReg, then MonAReg+1
//  take_no_action_ocimem_a  in  1        1-cycle pulse: read at MonAReg into MonDReg, then MonAReg+1
//  av_address               in  ADDR_W+1 bit ADDR_W=1 selects register page, else RAM word
//  av_read / av_write       in  1        Avalon strobes
//  av_writedata             in  32       write data
//  av_byteenable            in  4        RAM byte lanes; ignored on register page
//  av_readdata              out 32       valid in the cycle av_read is high and av_waitrequest low
//  av_waitrequest           out 1        stall
//  MonDReg                  out 32       JTAG read-back data
//  monitor_ready            out 1        set by CPU, cleared by JTAG go
//  monitor_error            out 1        set by CPU, cleared by JTAG go
//  monitor_go               out 1        level; set by JTAG, cleared by CPU control write
// BEHAVIOUR
//  Reset: MonDReg=0, MonAReg=0, ready/error/go=0, av_readdata=0, FSM=IDLE. RAM is not reset.
//  take_action_ocimem_a decode:
//   - jdo[34]: MonAReg<=jdo[ADDR_W+16:17].
//   - jdo[35]: read at the new address, with no increment.
//   - jdo[36]: monitor_go<=1; ready<=0; error<=0.
//   - All three bits are independent.
//  JTAG FSM: IDLE -> RD (RAM addr driven) -> CAP (MonDReg loaded, MonAReg+1 unless jdo[35] read) -> IDLE.
//   - MonDReg is valid 2 clk after the pulse.
//   - Write (action_b) completes in 1 cycle from IDLE.
//  Pulse arriving while FSM != IDLE: ignored; FSM, MonAReg and MonDReg are unchanged.
//  MonAReg wraps 2**ADDR_W-1 -> 0.
//  CPU RAM access:
//   - read: waitrequest high on the first cycle; readdata valid with waitrequest low next cycle (2-cycle minimum).
//   - write: completes in 1 cycle if no JTAG use.
//  Arbitration:
//   - A JTAG pulse or FSM != IDLE holds av_waitrequest=1; the CPU retries afterwards.
//   - Same-cycle JTAG and CPU write to the same word: JTAG first, then CPU, so CPU data is final.
//  Register page, offset 0:
//   - read returns {29'b0, monitor_go, monitor_error, monitor_ready}.
//   - write: bit0=1 sets ready, bit1=1 sets error, bit2=1 clears go; 1-cycle, no wait.
//  Same-cycle JTAG go (jdo[36]) and CPU set of ready/error: JTAG clear wins.
//  Reset mid-read: FSM returns to IDLE; any in-flight CPU or JTAG read is discarded.
// CONFIGURATION
//  CORE5_OCIMEM_WRITE_PROTECT_EN defined:
//   - CPU RAM writes with word addr < ROM_WORDS are dropped (1 cycle, no wait); monitor_error<=1.
//   - JTAG writes are unaffected.
//  Undefined: all addresses CPU-writable; ROM_WORDS is unused.
// TESTING
//  T1 action_a jdo[34]=1, jdo[24:17]=8'h10; action_b jdo[34:3]=32'hDEADBEEF; action_a jdo[34]=1,
//     jdo[35]=1, addr 8'h10 -> MonDReg=32'hDEADBEEF 2 clk later; MonAReg=8'h10.
//  T2 MonAReg=8'hFF, take_no_action_ocimem_a -> MonDReg=ram[255], MonAReg=8'h00 (wrap).
//  T3 CPU write 32'h12345678 addr 8'h20 in the same cycle as JTAG action_b 32'hAAAA5555 addr 8'h20
//     -> waitrequest 1 cycle; final ram[0x20]=32'h12345678.
//  T4 CPU writes reg 32'h3 -> ready=error=1; action_a jdo[36]=1 -> go=1, ready=error=0;
//     CPU writes reg 32'h4 -> go=0.
//  T5 WRITE_PROTECT_EN, ROM_WORDS=64: CPU write addr 8'h05 -> ram unchanged, error=1;
//     addr 8'h40 write lands.
//  T6 reset_n low during FSM RD -> all outputs reset; next action_a read completes normally.

Source files
------------

// File: rtl/core5_cpu_0_debug_ocimem_ctrl.sv
// core5_cpu_0_debug_ocimem_ctrl: OCIMEM debug RAM shared by JTAG and Avalon CPU slave, plus monitor flags
// Ports: clk, reset_n (async active-low); jdo + take_* pulses from the JTAG sysclk stage;
//   Avalon slave av_address/av_read/av_write/av_writedata/av_byteenable -> av_readdata/av_waitrequest;
//   MonDReg, monitor_ready, monitor_error, monitor_go back to the JTAG side.
// Option: CORE5_OCIMEM_WRITE_PROTECT_EN drops CPU writes below ROM_WORDS and flags monitor_error.
module core5_cpu_0_debug_ocimem_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int ROM_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W:0]   av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              monitor_go
);
`ifdef CORE5_OCIMEM_WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, RD, CAP} state_t;
    state_t state, nxt;
    logic [31:0] ram [2**ADDR_W];
    logic [ADDR_W-1:0] mon_a, ram_a, cpu_a;
    logic [31:0] rd_q, status;
    logic idle, busy, jwr, jrd, go_clr, reg_sel, reg_wr, ram_wr, prot, rd_go, pend, no_inc, unused;
    assign cpu_a   = av_address[ADDR_W-1:0];
    assign reg_sel = av_address[ADDR_W];
    assign idle    = state == IDLE;
    assign busy    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a | !idle;
    // Pulse priority a > b > no_action; pulses outside IDLE have no effect.
    assign jwr     = idle & !take_action_ocimem_a & take_action_ocimem_b;
    assign jrd     = idle & (take_action_ocimem_a ? jdo[35] : !take_action_ocimem_b & take_no_action_ocimem_a);
    assign go_clr  = idle & take_action_ocimem_a & jdo[36];
    assign reg_wr  = av_write & reg_sel & (cpu_a == '0);
    assign ram_wr  = av_write & !reg_sel & !busy;
    assign prot    = WP && (32'(cpu_a) < 32'(ROM_WORDS));
    assign rd_go   = av_read & !busy & !pend;
    assign status  = {29'b0, monitor_go, monitor_error, monitor_ready};
    assign ram_a   = (state == RD) ? mon_a : cpu_a;
    // Register-page writes never touch the RAM, so they are never stalled.
    assign av_waitrequest = !pend & (av_read | (av_write & !reg_sel & busy));
    assign av_readdata    = rd_q;
    assign unused  = &{1'b0, jdo[37], jdo[2:0]};
    always_comb begin
        nxt = (state == RD) ? CAP : jrd ? RD : IDLE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mon_a         <= '0;
            MonDReg       <= '0;
            no_inc        <= 1'b0;
            pend          <= 1'b0;
            rd_q          <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            monitor_go    <= 1'b0;
        end else begin
            pend <= rd_go;
            // Shared read register: JTAG address during RD, CPU address otherwise.
            rd_q <= (rd_go & reg_sel) ? ((cpu_a == '0) ? status : '0) : ram[ram_a];
            if (idle & take_action_ocimem_a & jdo[34]) mon_a <= jdo[ADDR_W+16:17];
            if (jwr | (state == CAP & !no_inc)) mon_a <= mon_a + 1'b1;
            if (jrd) no_inc <= take_action_ocimem_a;
            if (state == CAP) MonDReg <= rd_q;
            monitor_ready <= go_clr ? 1'b0 : monitor_ready | (reg_wr & av_writedata[0]);
            monitor_error <= go_clr ? 1'b0 : monitor_error | (reg_wr & av_writedata[1]) | (ram_wr & prot);
            monitor_go    <= go_clr ? 1'b1 : monitor_go & !(reg_wr & av_writedata[2]);
        end
    end
    always_ff @(posedge clk) begin
        if (jwr) ram[mon_a] <= jdo[34:3];
        else if (ram_wr & !prot)
            for (int i = 0; i < 4; i++)
                if (av_byteenable[i]) ram[cpu_a][8*i +: 8] <= av_writedata[8*i +: 8];
    end
endmodule
